// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - CPU/EXT arbiter for the single-port data memory
//
// Purpose: shares one single-port data memory (sync write, async read) between the
//   pipeline MEM stage (CPU port, priority) and an external requester (EXT port).
//   EXT is served in CPU-idle cycles, or forced in after MAX_WAIT starved cycles
//   while the CPU is stalled for that one slot.
//
// Ports:
//   clk, rst_n                      clock (rising edge), asynchronous active-low reset
//   i_cpu_read/i_cpu_write          MEM-stage load/store strobes
//   i_cpu_address/i_cpu_write_data  CPU word address and store data
//   o_cpu_read_data                 load data, 0 unless this is a granted CPU read
//   o_cpu_stall                     CPU access not performed this cycle
//   i_ext_req/i_ext_we              EXT request (held until ack), write/read select
//   i_ext_address/i_ext_write_data  EXT word address and write data
//   o_ext_ack                       one-cycle pulse in the cycle after the EXT slot
//   o_ext_read_data                 registered EXT read result, held after ack
//   o_mem_*                         address/data/enables to the memory
//   i_mem_read_data                 async read data from the memory
module data_mem_arbiter #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_cpu_read,
  input  logic                  i_cpu_write,
  input  logic [ADDR_WIDTH-1:0] i_cpu_address,
  input  logic [DATA_WIDTH-1:0] i_cpu_write_data,
  output logic [DATA_WIDTH-1:0] o_cpu_read_data,
  output logic                  o_cpu_stall,
  input  logic                  i_ext_req,
  input  logic                  i_ext_we,
  input  logic [ADDR_WIDTH-1:0] i_ext_address,
  input  logic [DATA_WIDTH-1:0] i_ext_write_data,
  output logic                  o_ext_ack,
  output logic [DATA_WIDTH-1:0] o_ext_read_data,
  output logic [ADDR_WIDTH-1:0] o_mem_address,
  output logic [DATA_WIDTH-1:0] o_mem_write_data,
  output logic                  o_mem_write,
  output logic                  o_mem_read,
  input  logic [DATA_WIDTH-1:0] i_mem_read_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FORCE = 2'd1,
    ACK   = 2'd2
  } state_t;

  // Counter value on the cycle whose starvation tips EXT into a forced slot.
  localparam logic [CNT_WIDTH-1:0] LAST_WAIT = CNT_WIDTH'(MAX_WAIT - 1);

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] wait_cnt, wait_cnt_nxt;
  logic                 cpu_active;
  logic                 ext_slot;
  logic                 cpu_grant;
  logic                 ext_go;
  logic                 cpu_go;

  assign cpu_active = i_cpu_read | i_cpu_write;

  // Next-state, starvation counter and slot ownership.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    ext_slot     = 1'b0;
    cpu_grant    = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_active) begin
          cpu_grant = 1'b1;
          if (i_ext_req) begin
            if (wait_cnt == LAST_WAIT) begin
              state_nxt    = FORCE;
              wait_cnt_nxt = '0;
            end else begin
              wait_cnt_nxt = wait_cnt + 1'b1;
            end
          end else begin
            wait_cnt_nxt = '0;
          end
        end else if (i_ext_req) begin
          ext_slot     = 1'b1;
          state_nxt    = ACK;
          wait_cnt_nxt = '0;
        end else begin
          wait_cnt_nxt = '0;
        end
      end
      FORCE: begin
        wait_cnt_nxt = '0;
        if (i_ext_req) begin
          ext_slot  = 1'b1;
          state_nxt = ACK;
        end else begin
          // Requester dropped out before its forced slot: give the cycle back.
          cpu_grant = cpu_active;
          state_nxt = IDLE;
        end
      end
      ACK: begin
        // Request is ignored here so a still-high req is not served twice.
        cpu_grant    = cpu_active;
        state_nxt    = IDLE;
        wait_cnt_nxt = '0;
      end
      default: begin
        state_nxt    = IDLE;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  // Memory accesses are suppressed while reset is asserted so that an
  // asynchronous reset mid-cycle cannot let a write reach the memory edge.
  assign ext_go      = ext_slot & rst_n;
  assign cpu_go      = cpu_grant & rst_n;
  assign o_cpu_stall = cpu_active & ~cpu_grant;
  assign o_ext_ack   = (state == ACK);

  always_comb begin
    o_mem_address    = '0;
    o_mem_write_data = '0;
    o_mem_write      = 1'b0;
    o_mem_read       = 1'b0;
    if (ext_go) begin
      o_mem_address    = i_ext_address;
      o_mem_write_data = i_ext_write_data;
      o_mem_write      = i_ext_we;
      o_mem_read       = ~i_ext_we;
    end else if (cpu_go) begin
      o_mem_address    = i_cpu_address;
      o_mem_write_data = i_cpu_write_data;
      o_mem_write      = i_cpu_write;
      o_mem_read       = i_cpu_read;
    end
  end

  assign o_cpu_read_data = (cpu_go && i_cpu_read) ? i_mem_read_data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      o_ext_read_data <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (ext_go && !i_ext_we) begin
        o_ext_read_data <= i_mem_read_data;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - directed table-driven bench for data_mem_arbiter
module tb_data_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cpu_read, cpu_write;
  logic [8:0]  cpu_address;
  logic [31:0] cpu_write_data, cpu_read_data;
  logic        cpu_stall;
  logic        ext_req, ext_we;
  logic [8:0]  ext_address;
  logic [31:0] ext_write_data, ext_read_data;
  logic        ext_ack;
  logic [8:0]  mem_address;
  logic [31:0] mem_write_data, mem_read_data;
  logic        mem_write, mem_read;

  int errors = 0;
  int checks = 0;

  data_mem_arbiter #(
    .ADDR_WIDTH(9), .DATA_WIDTH(32), .MAX_WAIT(4), .CNT_WIDTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cpu_read(cpu_read), .i_cpu_write(cpu_write),
    .i_cpu_address(cpu_address), .i_cpu_write_data(cpu_write_data),
    .o_cpu_read_data(cpu_read_data), .o_cpu_stall(cpu_stall),
    .i_ext_req(ext_req), .i_ext_we(ext_we),
    .i_ext_address(ext_address), .i_ext_write_data(ext_write_data),
    .o_ext_ack(ext_ack), .o_ext_read_data(ext_read_data),
    .o_mem_address(mem_address), .o_mem_write_data(mem_write_data),
    .o_mem_write(mem_write), .o_mem_read(mem_read),
    .i_mem_read_data(mem_read_data)
  );

  // Memory model: sync write, async read returning 0 when not enabled.
  logic [31:0] mem [512];
  initial for (int i = 0; i < 512; i++) mem[i] = '0;
  always @(posedge clk) if (mem_write) mem[mem_address] <= mem_write_data;
  assign mem_read_data = mem_read ? mem[mem_address] : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [8:0] ca, input logic [31:0] cd,
                       input logic er, input logic ew, input logic [8:0] ea, input logic [31:0] ed);
    cpu_read = cr; cpu_write = cw; cpu_address = ca; cpu_write_data = cd;
    ext_req = er; ext_we = ew; ext_address = ea; ext_write_data = ed;
  endtask

  typedef struct {
    logic        cr, cw;
    logic [8:0]  ca;
    logic [31:0] cd;
    logic        er, ew;
    logic [8:0]  ea;
    logic [31:0] ed;
    logic        x_stall, x_ack, x_mw, x_mr;
    logic [31:0] x_cpu_rd, x_ext_rd;
  } vec_t;

  vec_t vecs [19];

  initial begin
    //           cr    cw    ca     cd            er    ew    ea      ed           stall ack   mw    mr    cpu_rd        ext_rd
    vecs[0]  = '{1'b0, 1'b0, 9'd0,  32'h0,        1'b0, 1'b0, 9'd0,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[1]  = '{1'b0, 1'b1, 9'd5,  32'hDEADBEEF, 1'b0, 1'b0, 9'd0,   32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0};
    vecs[2]  = '{1'b1, 1'b0, 9'd5,  32'h0,        1'b0, 1'b0, 9'd0,   32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 9'd0,  32'h0,        1'b1, 1'b1, 9'h1FF, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0};
    vecs[4]  = '{1'b0, 1'b0, 9'd0,  32'h0,        1'b0, 1'b0, 9'd0,   32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[5]  = '{1'b0, 1'b0, 9'd0,  32'h0,        1'b1, 1'b0, 9'h1FF, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0};
    vecs[6]  = '{1'b0, 1'b0, 9'd0,  32'h0,        1'b0, 1'b0, 9'd0,   32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h12345678};
    vecs[7]  = '{1'b0, 1'b1, 9'd3,  32'h00000333, 1'b0, 1'b0, 9'd0,   32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h12345678};
    // CPU reads every cycle while EXT reads addr 3: four CPU cycles, then forced slot, then ack
    vecs[8]  = '{1'b1, 1'b0, 9'd5,  32'h0,        1'b1, 1'b0, 9'd3,   32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 32'h12345678};
    vecs[9]  = '{1'b1, 1'b0, 9'd5,  32'h0,        1'b1, 1'b0, 9'd3,   32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 32'h12345678};
    vecs[10] = '{1'b1, 1'b0, 9'd5,  32'h0,        1'b1, 1'b0, 9'd3,   32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 32'h12345678};
    vecs[11] = '{1'b1, 1'b0, 9'd5,  32'h0,        1'b1, 1'b0, 9'd3,   32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 32'h12345678};
    vecs[12] = '{1'b1, 1'b0, 9'd5,  32'h0,        1'b1, 1'b0, 9'd3,   32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h0,        32'h12345678};
    vecs[13] = '{1'b1, 1'b0, 9'd5,  32'h0,        1'b0, 1'b0, 9'd0,   32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 32'h00000333};
    // EXT write held through ack: slot, ack (ignored), slot again, ack
    vecs[14] = '{1'b0, 1'b0, 9'd0,  32'h0,        1'b1, 1'b1, 9'd10,  32'hAAAA0001, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h00000333};
    vecs[15] = '{1'b0, 1'b0, 9'd0,  32'h0,        1'b1, 1'b1, 9'd10,  32'hAAAA0001, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h00000333};
    vecs[16] = '{1'b0, 1'b0, 9'd0,  32'h0,        1'b1, 1'b1, 9'd10,  32'hAAAA0001, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h00000333};
    vecs[17] = '{1'b0, 1'b0, 9'd0,  32'h0,        1'b0, 1'b0, 9'd0,   32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h00000333};
    vecs[18] = '{1'b1, 1'b0, 9'd10, 32'h0,        1'b0, 1'b0, 9'd0,   32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'hAAAA0001, 32'h00000333};

    // Reset with random inputs
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 9'd0, 32'h0, 1'b0, 1'b0, 9'd0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 9'($urandom), $urandom,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 9'($urandom), $urandom);
      @(negedge clk);
      chk("rst_ack", 32'(ext_ack), 32'h0);
      chk("rst_stall", 32'(cpu_stall), 32'h0);
      chk("rst_ext_rd", ext_read_data, 32'h0);
      chk("rst_mem_write", 32'(mem_write), 32'h0);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 9'd0, 32'h0, 1'b0, 1'b0, 9'd0, 32'h0);
    rst_n = 1'b1;

    // Table vectors, one per cycle
    for (int i = 0; i < 19; i++) begin
      if (i != 0) begin
        @(posedge clk); #1;
      end
      drive(vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cd,
            vecs[i].er, vecs[i].ew, vecs[i].ea, vecs[i].ed);
      @(negedge clk);
      chk($sformatf("v%0d_stall", i), 32'(cpu_stall), 32'(vecs[i].x_stall));
      chk($sformatf("v%0d_ack", i), 32'(ext_ack), 32'(vecs[i].x_ack));
      chk($sformatf("v%0d_mem_write", i), 32'(mem_write), 32'(vecs[i].x_mw));
      chk($sformatf("v%0d_mem_read", i), 32'(mem_read), 32'(vecs[i].x_mr));
      chk($sformatf("v%0d_cpu_rd", i), cpu_read_data, vecs[i].x_cpu_rd);
      chk($sformatf("v%0d_ext_rd", i), ext_read_data, vecs[i].x_ext_rd);
    end

    // Reset asserted during a forced slot, CPU storing to addr 20 meanwhile
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 9'd20, 32'h00000BAD, 1'b1, 1'b0, 9'd3, 32'h0);
      @(negedge clk);
      chk($sformatf("starve%0d_stall", i), 32'(cpu_stall), 32'h0);
      chk($sformatf("starve%0d_mem_write", i), 32'(mem_write), 32'h1);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("force_stall", 32'(cpu_stall), 32'h1);
    chk("force_no_cpu_write", 32'(mem_write), 32'h0);
    chk("force_mem_read", 32'(mem_read), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_stall", 32'(cpu_stall), 32'h0);
    chk("midrst_mem_write", 32'(mem_write), 32'h0);
    chk("midrst_ack", 32'(ext_ack), 32'h0);
    chk("midrst_ext_rd", ext_read_data, 32'h0);
    @(posedge clk); #1;
    chk("midrst_ack_after_edge", 32'(ext_ack), 32'h0);
    drive(1'b0, 1'b0, 9'd0, 32'h0, 1'b0, 1'b0, 9'd0, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 9'd20, 32'h0, 1'b0, 1'b0, 9'd0, 32'h0);
    @(negedge clk);
    chk("post_rst_ack", 32'(ext_ack), 32'h0);
    chk("post_rst_cpu_rd20", cpu_read_data, 32'h00000BAD);
    chk("post_rst_stall", 32'(cpu_stall), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
